// File: rtl/pe_banked_if.sv
// Bundle of the data/handshake signals of one banked processing element:
// north/west inputs, south/east forwards, enable and overflow flag.
interface pe_banked_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_BANKS  = 4
);
    localparam int BANK_W = $clog2(NUM_BANKS);

    logic                  pe_enabled;
    logic [DATA_WIDTH-1:0] pe_psum_in;
    logic [DATA_WIDTH-1:0] pe_weight_in;
    logic                  pe_accept_w_in;
    logic [BANK_W-1:0]     pe_wbank_in;
    logic [DATA_WIDTH-1:0] pe_input_in;
    logic                  pe_valid_in;
    logic                  pe_switch_in;
    logic [BANK_W-1:0]     pe_sel_in;

    logic [DATA_WIDTH-1:0] pe_psum_out;
    logic [DATA_WIDTH-1:0] pe_weight_out;
    logic                  pe_accept_w_out;
    logic [BANK_W-1:0]     pe_wbank_out;
    logic [DATA_WIDTH-1:0] pe_input_out;
    logic                  pe_valid_out;
    logic                  pe_switch_out;
    logic [BANK_W-1:0]     pe_sel_out;
    logic                  pe_ovf_out;

    // Driver side (neighbouring cells or a bench)
    modport master (
        output pe_enabled, pe_psum_in, pe_weight_in, pe_accept_w_in, pe_wbank_in,
               pe_input_in, pe_valid_in, pe_switch_in, pe_sel_in,
        input  pe_psum_out, pe_weight_out, pe_accept_w_out, pe_wbank_out,
               pe_input_out, pe_valid_out, pe_switch_out, pe_sel_out, pe_ovf_out
    );

    // The processing element itself
    modport slave (
        input  pe_enabled, pe_psum_in, pe_weight_in, pe_accept_w_in, pe_wbank_in,
               pe_input_in, pe_valid_in, pe_switch_in, pe_sel_in,
        output pe_psum_out, pe_weight_out, pe_accept_w_out, pe_wbank_out,
               pe_input_out, pe_valid_out, pe_switch_out, pe_sel_out, pe_ovf_out
    );
endinterface

// File: rtl/pe_banked.sv
// Systolic-array processing element with NUM_BANKS preloadable background
// weights and one active weight. Saturating Q-format MAC, sticky overflow.
module pe_banked #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int NUM_BANKS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    pe_banked_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int PW     = 2 * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] psum_q,   psum_d;
    logic [DATA_WIDTH-1:0] weight_q, weight_d;
    logic [DATA_WIDTH-1:0] input_q,  input_d;
    logic [DATA_WIDTH-1:0] act_w_q,  act_w_d;
    logic                  accept_q, accept_d;
    logic [BANK_W-1:0]     wbank_q,  wbank_d;
    logic                  valid_q,  valid_d;
    logic                  switch_q, switch_d;
    logic [BANK_W-1:0]     sel_q,    sel_d;
    logic                  ovf_q,    ovf_d;

    // Read view of all background banks
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;
    logic                                 sel_ok;

    logic signed [PW-1:0]  prod_full;
    logic signed [PW-1:0]  prod_shift;
    logic                  prod_ovf;
    logic [DATA_WIDTH-1:0] prod_sat;
    logic [DATA_WIDTH:0]   sum_full;
    logic                  sum_ovf;
    logic [DATA_WIDTH-1:0] sum_sat;

    // A select index beyond the last bank only exists for non-power-of-2 counts
    generate
        if ((1 << BANK_W) == NUM_BANKS) begin : g_sel_pow2
            assign sel_ok = 1'b1;
        end else begin : g_sel_range
            localparam logic [BANK_W:0] NB = (BANK_W + 1)'(NUM_BANKS);
            assign sel_ok = ({1'b0, bus.pe_sel_in} < NB);
        end
    endgenerate

    // One register per background bank, written by a matching weight load
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] bank_q, bank_d;

            // Bank next value: clear when disabled, load on matching strobe
            always_comb begin
                bank_d = bank_q;
                if (!bus.pe_enabled) begin
                    bank_d = '0;
                end else if (bus.pe_accept_w_in && (bus.pe_wbank_in == BANK_W'(gi))) begin
                    bank_d = bus.pe_weight_in;
                end
            end

            // Bank storage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) bank_q <= '0;
                else        bank_q <= bank_d;
            end

            assign bank_rd[gi] = bank_q;
        end
    endgenerate

    // MAC datapath on registered operands: floor-shifted product and sum,
    // each saturated to the word range
    always_comb begin
        prod_full  = PW'($signed(input_q)) * PW'($signed(act_w_q));
        prod_shift = prod_full >>> FRAC_BITS;
        // Fits in DATA_WIDTH only if all bits above the sign bit agree with it
        prod_ovf   = !(&prod_shift[PW-1:DATA_WIDTH-1]) && (|prod_shift[PW-1:DATA_WIDTH-1]);
        prod_sat   = prod_ovf ? (prod_shift[PW-1] ? SAT_MIN : SAT_MAX)
                              : prod_shift[DATA_WIDTH-1:0];
        sum_full   = {prod_sat[DATA_WIDTH-1], prod_sat}
                   + {bus.pe_psum_in[DATA_WIDTH-1], bus.pe_psum_in};
        sum_ovf    = sum_full[DATA_WIDTH] ^ sum_full[DATA_WIDTH-1];
        sum_sat    = sum_ovf ? (sum_full[DATA_WIDTH] ? SAT_MIN : SAT_MAX)
                             : sum_full[DATA_WIDTH-1:0];
    end

    // Next state of forwards, active weight, psum and overflow flag
    always_comb begin
        psum_d   = psum_q;
        weight_d = weight_q;
        input_d  = input_q;
        act_w_d  = act_w_q;
        accept_d = accept_q;
        wbank_d  = wbank_q;
        valid_d  = valid_q;
        switch_d = switch_q;
        sel_d    = sel_q;
        ovf_d    = ovf_q;
        if (!bus.pe_enabled) begin
            psum_d   = '0;
            weight_d = '0;
            input_d  = '0;
            act_w_d  = '0;
            accept_d = 1'b0;
            wbank_d  = '0;
            valid_d  = 1'b0;
            switch_d = 1'b0;
            sel_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            valid_d  = bus.pe_valid_in;
            switch_d = bus.pe_switch_in;
            sel_d    = bus.pe_sel_in;
            accept_d = bus.pe_accept_w_in;
            wbank_d  = bus.pe_wbank_in;
            if (bus.pe_valid_in) begin
                input_d = bus.pe_input_in;
            end
            weight_d = bus.pe_accept_w_in ? bus.pe_weight_in : '0;
            // Same-edge write to the selected bank is forwarded; otherwise the
            // pre-write bank contents are taken
            if (bus.pe_switch_in && sel_ok) begin
                act_w_d = (bus.pe_accept_w_in && (bus.pe_wbank_in == bus.pe_sel_in))
                        ? bus.pe_weight_in : bank_rd[bus.pe_sel_in];
            end
            if (valid_q) begin
                psum_d = sum_sat;
                if (prod_ovf || sum_ovf) begin
                    ovf_d = 1'b1;
                end
            end else begin
                psum_d = bus.pe_psum_in;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psum_q   <= '0;
            weight_q <= '0;
            input_q  <= '0;
            act_w_q  <= '0;
            accept_q <= 1'b0;
            wbank_q  <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
            sel_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            psum_q   <= psum_d;
            weight_q <= weight_d;
            input_q  <= input_d;
            act_w_q  <= act_w_d;
            accept_q <= accept_d;
            wbank_q  <= wbank_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
            sel_q    <= sel_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.pe_psum_out     = psum_q;
    assign bus.pe_weight_out   = weight_q;
    assign bus.pe_accept_w_out = accept_q;
    assign bus.pe_wbank_out    = wbank_q;
    assign bus.pe_input_out    = input_q;
    assign bus.pe_valid_out    = valid_q;
    assign bus.pe_switch_out   = switch_q;
    assign bus.pe_sel_out      = sel_q;
    assign bus.pe_ovf_out      = ovf_q;
endmodule

// File: tb/tb_pe_banked.sv
// Bench for pe_banked: directed scenarios plus random traffic, compared
// every cycle against an arithmetic reference model of the PE.
module tb_pe_banked;
    logic clk = 1'b0;
    logic rst_n;

    pe_banked_if #(.DATA_WIDTH(16), .NUM_BANKS(4)) bus ();

    pe_banked #(.DATA_WIDTH(16), .FRAC_BITS(8), .NUM_BANKS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [15:0] m_psum, m_wout, m_in, m_act;
    logic        m_acc, m_vout, m_sw, m_ovf;
    logic [1:0]  m_wb, m_sel;
    logic [15:0] m_bank [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_psum = '0; m_wout = '0; m_in = '0; m_act = '0;
        m_acc = 1'b0; m_vout = 1'b0; m_sw = 1'b0; m_ovf = 1'b0;
        m_wb = '0; m_sel = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = '0;
    endtask

    // Clamp to the signed 16-bit range, flag if clamped
    function automatic longint clamp16(input longint v, inout logic flag);
        if (v > 32767) begin flag = 1'b1; return 32767; end
        if (v < -32768) begin flag = 1'b1; return -32768; end
        return v;
    endfunction

    // Apply the effect of one enabled clock edge with the current inputs
    task automatic model_edge();
        longint p, q, s;
        if (!bus.pe_enabled) begin
            model_clear();
            return;
        end
        if (m_vout) begin
            p = longint'($signed(m_in)) * longint'($signed(m_act));
            q = p / 256;                       // truncates toward zero
            if (p < 0 && (p % 256) != 0) q = q - 1; // make it floor
            q = clamp16(q, m_ovf);
            s = q + longint'($signed(bus.pe_psum_in));
            s = clamp16(s, m_ovf);
            m_psum = 16'(s);
        end else begin
            m_psum = bus.pe_psum_in;
        end
        if (bus.pe_switch_in) begin
            if (bus.pe_accept_w_in && bus.pe_wbank_in == bus.pe_sel_in) m_act = bus.pe_weight_in;
            else m_act = m_bank[bus.pe_sel_in];
        end
        if (bus.pe_accept_w_in) m_bank[bus.pe_wbank_in] = bus.pe_weight_in;
        m_wout = bus.pe_accept_w_in ? bus.pe_weight_in : 16'h0000;
        if (bus.pe_valid_in) m_in = bus.pe_input_in;
        m_vout = bus.pe_valid_in;
        m_sw   = bus.pe_switch_in;
        m_sel  = bus.pe_sel_in;
        m_acc  = bus.pe_accept_w_in;
        m_wb   = bus.pe_wbank_in;
    endtask

    task automatic compare_all();
        check_eq("psum_out",   32'(bus.pe_psum_out),     32'(m_psum));
        check_eq("weight_out", 32'(bus.pe_weight_out),   32'(m_wout));
        check_eq("input_out",  32'(bus.pe_input_out),    32'(m_in));
        check_eq("accept_out", 32'(bus.pe_accept_w_out), 32'(m_acc));
        check_eq("wbank_out",  32'(bus.pe_wbank_out),    32'(m_wb));
        check_eq("valid_out",  32'(bus.pe_valid_out),    32'(m_vout));
        check_eq("switch_out", 32'(bus.pe_switch_out),   32'(m_sw));
        check_eq("sel_out",    32'(bus.pe_sel_out),      32'(m_sel));
        check_eq("ovf_out",    32'(bus.pe_ovf_out),      32'(m_ovf));
        $display("cyc t=%0t en=%0b psum_out=%h ovf=%0b in_out=%h w_out=%h",
                 $time, bus.pe_enabled, bus.pe_psum_out, bus.pe_ovf_out,
                 bus.pe_input_out, bus.pe_weight_out);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cyc(input logic v, input logic [15:0] in, input logic [15:0] ps,
                       input logic acc, input logic [1:0] wb, input logic [15:0] w,
                       input logic sw, input logic [1:0] sel);
        bus.pe_valid_in    = v;
        bus.pe_input_in    = in;
        bus.pe_psum_in     = ps;
        bus.pe_accept_w_in = acc;
        bus.pe_wbank_in    = wb;
        bus.pe_weight_in   = w;
        bus.pe_switch_in   = sw;
        bus.pe_sel_in      = sel;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.pe_enabled = 1'b0;
        bus.pe_valid_in = 1'b0; bus.pe_input_in = '0; bus.pe_psum_in = '0;
        bus.pe_accept_w_in = 1'b0; bus.pe_wbank_in = '0; bus.pe_weight_in = '0;
        bus.pe_switch_in = 1'b0; bus.pe_sel_in = '0;
        model_clear();
        #1 rst_n = 1'b0;
        #2 compare_all();              // reset state
        @(posedge clk); #2 rst_n = 1'b1;
        bus.pe_enabled = 1'b1;

        // Basic MAC with same-edge load+switch forwarding
        cyc(1, 16'h0180, 16'h0000, 1, 2'd1, 16'h0200, 1, 2'd1);
        cyc(1, 16'hFE80, 16'h0100, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp1_psum", 32'(bus.pe_psum_out), 32'h0400);
        check_eq("tp1_ovf", 32'(bus.pe_ovf_out), 32'h0);
        // Negative product and floor rounding at +/-1 LSB
        cyc(1, 16'h0001, 16'h0000, 1, 2'd2, 16'h0080, 1, 2'd2);
        check_eq("tp2_neg", 32'(bus.pe_psum_out), 32'hFD00);
        cyc(1, 16'hFFFF, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp2_floor_pos", 32'(bus.pe_psum_out), 32'h0000);
        cyc(0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp2_floor_neg", 32'(bus.pe_psum_out), 32'hFFFF);

        // Product saturation and sticky overflow
        cyc(1, 16'h7F00, 16'h0000, 0, 2'd0, 16'h0000, 1, 2'd1);
        cyc(1, 16'h0100, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp3_sat", 32'(bus.pe_psum_out), 32'h7FFF);
        check_eq("tp3_ovf_set", 32'(bus.pe_ovf_out), 32'h1);
        cyc(0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp3_nosat", 32'(bus.pe_psum_out), 32'h0200);
        check_eq("tp3_ovf_sticky", 32'(bus.pe_ovf_out), 32'h1);
        bus.pe_enabled = 1'b0;
        step();
        check_eq("tp3_ovf_clear", 32'(bus.pe_ovf_out), 32'h0);
        bus.pe_enabled = 1'b1;

        // Preload all banks, then switch through them
        for (int i = 0; i < 4; i++)
            cyc(0, 16'h0000, 16'h0000, 1, 2'(i), 16'((i + 1) * 256), 0, 2'd0);
        cyc(1, 16'h0100, 16'h0000, 0, 2'd0, 16'h0000, 1, 2'd3);
        cyc(1, 16'h0100, 16'h0000, 0, 2'd0, 16'h0000, 1, 2'd0);
        check_eq("tp4_sel3", 32'(bus.pe_psum_out), 32'h0400);
        cyc(1, 16'h0100, 16'h0000, 0, 2'd0, 16'h0000, 1, 2'd2);
        check_eq("tp4_sel0", 32'(bus.pe_psum_out), 32'h0100);
        cyc(1, 16'h0100, 16'h0000, 1, 2'd2, 16'h0700, 0, 2'd0);
        check_eq("tp4_sel2", 32'(bus.pe_psum_out), 32'h0300);
        cyc(0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp4_hold_active", 32'(bus.pe_psum_out), 32'h0300);

        // Same-edge load/switch: same bank forwards, other bank reads old value
        cyc(1, 16'h0100, 16'h0000, 1, 2'd2, 16'h0500, 1, 2'd2);
        cyc(1, 16'h0100, 16'h0000, 1, 2'd1, 16'h0900, 1, 2'd2);
        check_eq("tp5_fwd", 32'(bus.pe_psum_out), 32'h0500);
        cyc(0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp5_old_bank", 32'(bus.pe_psum_out), 32'h0500);

        // Asynchronous reset mid-stream, then pass-through
        cyc(1, 16'h0300, 16'h0000, 1, 2'd3, 16'h1111, 1, 2'd1);
        #1 rst_n = 1'b0;
        #1 model_clear();
        compare_all();
        check_eq("tp6_async_psum", 32'(bus.pe_psum_out), 32'h0);
        #1 rst_n = 1'b1;
        cyc(0, 16'h0000, 16'h1234, 0, 2'd0, 16'h0000, 0, 2'd0);
        check_eq("tp6_passthru", 32'(bus.pe_psum_out), 32'h1234);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [15:0] w, a;
            w = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
            a = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
            bus.pe_enabled = ($urandom_range(0, 31) != 0);
            cyc(1'($urandom), a, 16'($urandom), 1'($urandom), 2'($urandom),
                w, ($urandom_range(0, 3) == 0), 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
